// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external Hack ALU between requesters A and B; optional counters under ALU_ARB_STATS_EN.
// Accept at cycle N, resp_valid at N+2. No new accept until the owner's result handshake completes.
module alu_share_arbiter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_req_valid,
    output logic         a_req_ready,
    input  logic [W-1:0] a_x,
    input  logic [W-1:0] a_y,
    input  logic [5:0]   a_ctrl,
    output logic         a_resp_valid,
    input  logic         a_resp_ready,
    output logic [W-1:0] a_out,
    output logic         a_zr,
    output logic         a_ng,
    input  logic         b_req_valid,
    output logic         b_req_ready,
    input  logic [W-1:0] b_x,
    input  logic [W-1:0] b_y,
    input  logic [5:0]   b_ctrl,
    output logic         b_resp_valid,
    input  logic         b_resp_ready,
    output logic [W-1:0] b_out,
    output logic         b_zr,
    output logic         b_ng,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic [5:0]   alu_ctrl,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zr,
    input  logic         alu_ng,
    output logic         busy
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic         stats_clr,
    output logic [15:0]  a_grant_cnt,
    output logic [15:0]  b_grant_cnt,
    output logic [15:0]  contend_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e         state_q, state_d;
    logic           ptr_q, ptr_d;      // 0 = A has priority, 1 = B
    logic           owner_q, owner_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d;
    logic [5:0]     ctrl_q, ctrl_d;
    logic [W-1:0]   a_out_q, a_out_d, b_out_q, b_out_d;
    logic           a_zr_q, a_zr_d, a_ng_q, a_ng_d;
    logic           b_zr_q, b_zr_d, b_ng_q, b_ng_d;
    logic           grant_a, grant_b;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        x_d          = x_q;
        y_d          = y_q;
        ctrl_d       = ctrl_q;
        a_out_d      = a_out_q;
        a_zr_d       = a_zr_q;
        a_ng_d       = a_ng_q;
        b_out_d      = b_out_q;
        b_zr_d       = b_zr_q;
        b_ng_d       = b_ng_q;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        a_resp_valid = 1'b0;
        b_resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ready is suppressed while reset is asserted so nothing is accepted then.
                if (!reset) begin
                    if (a_req_valid && (!ptr_q || !b_req_valid)) begin
                        grant_a = 1'b1;
                    end else if (b_req_valid) begin
                        grant_b = 1'b1;
                    end
                end
                if (grant_a) begin
                    x_d     = a_x;
                    y_d     = a_y;
                    ctrl_d  = a_ctrl;
                    owner_d = 1'b0;
                    state_d = EXEC;
                end else if (grant_b) begin
                    x_d     = b_x;
                    y_d     = b_y;
                    ctrl_d  = b_ctrl;
                    owner_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!owner_q) begin
                    a_out_d = alu_out;
                    a_zr_d  = alu_zr;
                    a_ng_d  = alu_ng;
                end else begin
                    b_out_d = alu_out;
                    b_zr_d  = alu_zr;
                    b_ng_d  = alu_ng;
                end
                state_d = RESP;
            end
            RESP: begin
                a_resp_valid = !owner_q;
                b_resp_valid = owner_q;
                if (owner_q ? b_resp_ready : a_resp_ready) begin
                    state_d = IDLE;
                    ptr_d   = !owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ctrl_q  <= '0;
            a_out_q <= '0;
            a_zr_q  <= 1'b0;
            a_ng_q  <= 1'b0;
            b_out_q <= '0;
            b_zr_q  <= 1'b0;
            b_ng_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ctrl_q  <= ctrl_d;
            a_out_q <= a_out_d;
            a_zr_q  <= a_zr_d;
            a_ng_q  <= a_ng_d;
            b_out_q <= b_out_d;
            b_zr_q  <= b_zr_d;
            b_ng_q  <= b_ng_d;
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign a_out       = a_out_q;
    assign a_zr        = a_zr_q;
    assign a_ng        = a_ng_q;
    assign b_out       = b_out_q;
    assign b_zr        = b_zr_q;
    assign b_ng        = b_ng_q;
    assign alu_x       = x_q;
    assign alu_y       = y_q;
    assign alu_ctrl    = ctrl_q;
    assign busy        = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [15:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, c_cnt_q, c_cnt_d;

    // Saturating counters; a clear in the same cycle as an increment wins.
    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        c_cnt_d = c_cnt_q;
        if (grant_a && a_cnt_q != 16'hFFFF) a_cnt_d = a_cnt_q + 16'd1;
        if (grant_b && b_cnt_q != 16'hFFFF) b_cnt_d = b_cnt_q + 16'd1;
        if ((grant_a || grant_b) && a_req_valid && b_req_valid && c_cnt_q != 16'hFFFF)
            c_cnt_d = c_cnt_q + 16'd1;
        if (stats_clr) begin
            a_cnt_d = '0;
            b_cnt_d = '0;
            c_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            c_cnt_q <= c_cnt_d;
        end
    end

    assign a_grant_cnt = a_cnt_q;
    assign b_grant_cnt = b_cnt_q;
    assign contend_cnt = c_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed protocol scenarios, then random traffic against a transaction model.
// Provides the external Hack ALU; counters are exercised when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_zr, a_ng;
    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_zr, b_ng;
    logic [15:0] a_x, a_y, a_out, b_x, b_y, b_out;
    logic [5:0]  a_ctrl, b_ctrl, alu_ctrl;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zr, alu_ng, busy;
`ifdef ALU_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] a_grant_cnt, b_grant_cnt, contend_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit mptr  = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.W(16)) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_x(a_x), .a_y(a_y), .a_ctrl(a_ctrl),
        .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready), .a_out(a_out), .a_zr(a_zr), .a_ng(a_ng),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_x(b_x), .b_y(b_y), .b_ctrl(b_ctrl),
        .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready), .b_out(b_out), .b_zr(b_zr), .b_ng(b_ng),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .busy(busy)
`ifdef ALU_ARB_STATS_EN
        , .stats_clr(stats_clr), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt), .contend_cnt(contend_cnt)
`endif
    );

    // Hack ALU semantics: returns {out, zr, ng}.
    function automatic logic [17:0] hack(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return {o, (o == 16'h0000), o[15]};
    endfunction

    always_comb {alu_out, alu_zr, alu_ng} = hack(alu_x, alu_y, alu_ctrl);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit side, input bit v, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] c);
        if (!side) begin
            a_req_valid = v; a_x = x; a_y = y; a_ctrl = c;
        end else begin
            b_req_valid = v; b_x = x; b_y = y; b_ctrl = c;
        end
    endtask

    // Entered and left at posedge+1; single uncontended operation with ready already high.
    task automatic do_op(input bit side, input logic [15:0] x, input logic [15:0] y, input logic [5:0] c,
                         input logic [17:0] exp, input string tag);
        drive(side, 1'b1, x, y, c);
        a_resp_ready = (side == 1'b0);
        b_resp_ready = (side == 1'b1);
        @(negedge clk);
        chk({tag, "_ready"}, side ? b_req_ready : a_req_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        @(posedge clk); #1;
        drive(side, 1'b0, x, y, c);
        @(negedge clk);
        chk({tag, "_exec_busy"}, busy, 1);
        chk({tag, "_alu_in"}, {alu_x, alu_y, alu_ctrl}, {x, y, c});
        chk({tag, "_exec_rv"}, {a_resp_valid, b_resp_valid}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_resp_rv"}, {a_resp_valid, b_resp_valid}, side ? 2'b01 : 2'b10);
        chk({tag, "_result"}, side ? {b_out, b_zr, b_ng} : {a_out, a_zr, a_ng}, exp);
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        b_resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_back_idle"}, busy, 0);
        @(posedge clk); #1;
        mptr = !side;
    endtask

    initial begin
        int          gs[$];
        int          gc[$];
        int          a_seen;
        bit          rv[2];
        logic [15:0] rx[2], ry[2];
        logic [5:0]  rc[2];
        bit          mout;
        bit          mown;
        int          macc, acc, nops, ws;
        logic [17:0] mexp;
        logic [1:0]  erdy, erv;

        reset = 1'b1;
        drive(0, 1'b1, 16'd0, 16'd0, 6'd0);
        drive(1, 1'b1, 16'd0, 16'd0, 6'd0);
        a_resp_ready = 1'b0;
        b_resp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready", {a_req_ready, b_req_ready}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 16'd0, 16'd0, 6'd0);
        drive(1, 1'b0, 16'd0, 16'd0, 6'd0);
        @(negedge clk);
        chk("rst_resp_busy", {a_resp_valid, b_resp_valid, busy}, 3'b000);
        chk("rst_results", {a_out, a_zr, a_ng, b_out, b_zr, b_ng}, 36'd0);
        chk("rst_alu_in", {alu_x, alu_y, alu_ctrl}, 38'd0);
        @(posedge clk); #1;

        // Single-requester operations and flag checks.
        do_op(0, 16'd5, 16'd3, 6'b000010, {16'd8, 1'b0, 1'b0}, "a_add");
        chk("a_add_b_untouched", {b_out, b_zr, b_ng}, 18'd0);
        do_op(1, 16'h1234, 16'h5678, 6'b101010, {16'd0, 1'b1, 1'b0}, "b_zero");
        do_op(1, 16'h1234, 16'h5678, 6'b111010, {16'hFFFF, 1'b0, 1'b1}, "b_minus1");
        chk("b_ops_a_held", {a_out, a_zr, a_ng}, {16'd8, 2'b00});

`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
`endif

        // Continuous contention: grants alternate starting from the pointer side.
        drive(0, 1'b1, 16'd1, 16'd1, 6'b000010);
        drive(1, 1'b1, 16'd7, 16'd2, 6'b010011);
        a_resp_ready = 1'b1;
        b_resp_ready = 1'b1;
        a_seen = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (a_req_ready) begin gs.push_back(0); gc.push_back(cyc); end
            if (b_req_ready) begin gs.push_back(1); gc.push_back(cyc); end
            if (a_resp_valid) begin
                a_seen++;
                chk("cont_a_result", {a_out, a_zr, a_ng}, {16'd2, 2'b00});
            end
            if (b_resp_valid) chk("cont_b_result", {b_out, b_zr, b_ng}, {16'd5, 2'b00});
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 16'd0, 16'd0, 6'd0);
        drive(1, 1'b0, 16'd0, 16'd0, 6'd0);
        a_resp_ready = 1'b0;
        b_resp_ready = 1'b0;
        chk("cont_ngrants", gs.size(), 4);
        chk("cont_a_results", a_seen, 2);
        for (int i = 0; i < gs.size(); i++) begin
            chk("cont_side", gs[i], mptr ^ (i % 2));
            if (i == 0) chk("cont_first_cyc", gc[i], 0);
            else        chk("cont_gap", gc[i] - gc[i-1], 3);
        end
`ifdef ALU_ARB_STATS_EN
        chk("stats_counts", {a_grant_cnt, b_grant_cnt, contend_cnt}, {16'd2, 16'd2, 16'd4});
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_cleared", {a_grant_cnt, b_grant_cnt, contend_cnt}, 48'd0);
        @(posedge clk); #1;
`endif

        // A result held under backpressure while B waits.
        drive(0, 1'b1, 16'h00F0, 16'h0FF0, 6'b000000);
        @(negedge clk);
        chk("hold_a_ready", a_req_ready, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'd0, 16'd0, 6'd0);
        drive(1, 1'b1, 16'd3, 16'd4, 6'b000010);
        @(negedge clk);
        chk("hold_exec_b_ready", b_req_ready, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_state", {a_resp_valid, b_resp_valid, busy, b_req_ready}, 4'b1010);
            chk("hold_a_result", {a_out, a_zr, a_ng}, {16'h00F0, 2'b00});
            @(posedge clk); #1;
        end
        a_resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_rv", a_resp_valid, 1);
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        @(negedge clk);
        chk("hold_b_granted", {a_req_ready, b_req_ready}, 2'b01);
        @(posedge clk); #1;
        drive(1, 1'b0, 16'd0, 16'd0, 6'd0);
        b_resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_b_result", {b_resp_valid, b_out, b_zr, b_ng}, {1'b1, 16'd7, 2'b00});
        @(posedge clk); #1;
        b_resp_ready = 1'b0;
        mptr = 1'b0;

        // Reset during EXEC aborts and returns priority to A.
        do_op(0, 16'd9, 16'd1, 6'b000010, {16'd10, 2'b00}, "pre_abort");
        drive(0, 1'b1, 16'd2, 16'd2, 6'b000010);
        @(negedge clk);
        chk("abort_accept", a_req_ready, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'd0, 16'd0, 6'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_in_exec", busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_idle", {busy, a_resp_valid, b_resp_valid}, 3'b000);
        chk("abort_a_out", a_out, 16'd0);
        @(posedge clk); #1;
        drive(0, 1'b1, 16'd2, 16'd2, 6'b000010);
        drive(1, 1'b1, 16'd2, 16'd2, 6'b000010);
        @(negedge clk);
        chk("abort_ptr_a", {a_req_ready, b_req_ready}, 2'b10);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'd0, 16'd0, 6'd0);
        drive(1, 1'b0, 16'd0, 16'd0, 6'd0);
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        mptr = 1'b1;

        // Random traffic against a transaction-level model.
        rv[0] = 1'b0; rv[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin rx[s] = '0; ry[s] = '0; rc[s] = '0; end
        mout = 1'b0; mown = 1'b0; macc = 0; mexp = '0; nops = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            erdy = 2'b00;
            if (!mout && (rv[0] || rv[1])) begin
                ws = rv[mptr] ? int'(mptr) : int'(!mptr);
                erdy = (ws == 1) ? 2'b01 : 2'b10;
            end
            chk("rnd_ready", {a_req_ready, b_req_ready}, erdy);
            erv = (mout && (cyc - macc) >= 2) ? (mown ? 2'b01 : 2'b10) : 2'b00;
            chk("rnd_resp_valid", {a_resp_valid, b_resp_valid}, erv);
            acc = -1;
            if (mout && (cyc - macc) >= 2 && (mown ? b_resp_ready : a_resp_ready)) begin
                chk("rnd_result", mown ? {b_out, b_zr, b_ng} : {a_out, a_zr, a_ng}, mexp);
                mout = 1'b0;
                mptr = !mown;
                nops++;
            end else if (erdy != 2'b00) begin
                mout = 1'b1;
                mown = erdy[0];
                macc = cyc;
                mexp = hack(rx[mown], ry[mown], rc[mown]);
                acc  = int'(mown);
            end
            @(posedge clk); #1;
            if (acc >= 0) rv[acc] = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (!rv[s] && $urandom_range(2) == 0) begin
                    rv[s] = 1'b1;
                    rx[s] = 16'($urandom);
                    ry[s] = 16'($urandom);
                    rc[s] = 6'($urandom);
                end
                drive(s[0], rv[s], rx[s], ry[s], rc[s]);
            end
            a_resp_ready = 1'($urandom_range(1));
            b_resp_ready = 1'($urandom_range(1));
        end
        chk("rnd_progress", nops > 20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
